// File: rtl/mfrc522_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : mfrc522_spi_slave
// Purpose  : SPI mode-0 slave exposing a small MFRC522-style register file:
//            CommandReg (0x01), ErrorReg (0x06), FIFODataReg (0x09),
//            FIFOLevelReg (0x0A), VersionReg (0x37) and 8-bit scratch
//            registers at every other address.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            cs_n - SPI chip select, active low (asynchronous to clk)
//            sck  - SPI clock, CPOL=0 CPHA=0, MSB first (asynchronous)
//            mosi - master-to-slave data (asynchronous)
//            miso - slave-to-master data, 0 while deselected
//            irq  - (MFRC522_SLAVE_IRQ_EN only) FIFO level >= WaterLevelReg
//                   or BufferOvfl set; WaterLevelReg lives at 0x0B
// Options  : define MFRC522_SLAVE_IRQ_EN to add irq and WaterLevelReg.
// Revision : 1.0 - initial release
// ============================================================================
module mfrc522_spi_slave #(
    parameter int         FIFO_DEPTH  = 64,
    parameter logic [7:0] VERSION_VAL = 8'h92,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic sck,
    input  logic mosi,
    output logic miso
`ifdef MFRC522_SLAVE_IRQ_EN
    ,
    output logic irq
`endif
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ADDR = 2'd1;
    localparam logic [1:0] c_ST_DATA = 2'd2;

    localparam logic [5:0] c_A_COMMAND   = 6'h01;
    localparam logic [5:0] c_A_ERROR     = 6'h06;
    localparam logic [5:0] c_A_FIFODATA  = 6'h09;
    localparam logic [5:0] c_A_FIFOLEVEL = 6'h0A;
    localparam logic [5:0] c_A_VERSION   = 6'h37;
`ifdef MFRC522_SLAVE_IRQ_EN
    localparam logic [5:0] c_A_WATER     = 6'h0B;
`endif

    localparam logic [3:0]      c_CMD_SOFTRESET = 4'hF;
    localparam logic [c_AW-1:0] c_PTR_ONE       = 1;
    localparam logic [c_LW-1:0] c_LVL_ONE       = 1;
    localparam logic [c_LW-1:0] c_LVL_FULL      = c_LW'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection.
    // The cs_n chain resets low so that a frame still in progress when
    // rst is released is not mistaken for a new cs_n fall; only a real
    // high-to-low transition afterwards opens a frame.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_cs_d;
    logic                   r_sck_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_sync   <= '0;
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_cs_d      <= 1'b0;
            r_sck_d     <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
        end
    end

    logic w_cs_s;
    logic w_sck_s;
    logic w_mosi_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_sck_fall;

    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_fall  = r_cs_d & ~w_cs_s;
    assign w_cs_rise  = ~r_cs_d & w_cs_s;
    assign w_sck_rise = ~r_sck_d & w_sck_s;
    assign w_sck_fall = r_sck_d & ~w_sck_s;

    // ------------------------------------------------------------------
    // Frame state
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx;
    logic [7:0] r_tx;
    logic       r_miso;
    logic       r_rd;
    logic [5:0] r_addr;
    logic       r_wr_stb;
    logic [7:0] r_wr_data;

    // Register file / FIFO state
    logic [3:0]      r_command;
    logic            r_buf_ovfl;
    logic [7:0]      r_scratch [64];
    logic [7:0]      r_fifo_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
`ifdef MFRC522_SLAVE_IRQ_EN
    logic [7:0]      r_water;
    logic            r_irq;
`endif

    logic [7:0] w_rx_next;
    logic       w_byte_done;
    logic       w_load;
    logic [5:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic       w_fifo_empty;
    logic       w_fifo_full;
    logic       w_pop;
    logic       w_push;
    logic       w_soft_rst;
    logic       w_flush;

    assign w_rx_next   = {r_rx, w_mosi_s};
    assign w_byte_done = w_sck_rise && !w_cs_rise && (r_bit_cnt == 3'd7) &&
                         (r_state != c_ST_IDLE);
    // A read byte is loaded at the end of the address byte (read frame) and
    // at the end of every following byte, which doubles as the next address.
    assign w_load      = w_byte_done &&
                         ((r_state == c_ST_ADDR) ? w_rx_next[7] : r_rd);
    assign w_rd_addr   = w_rx_next[6:1];

    assign w_fifo_empty = (r_level == '0);
    assign w_fifo_full  = (r_level == c_LVL_FULL);
    assign w_pop        = w_load && (w_rd_addr == c_A_FIFODATA) && !w_fifo_empty;
    assign w_push       = r_wr_stb && (r_addr == c_A_FIFODATA) && !w_fifo_full;
    assign w_soft_rst   = r_wr_stb && (r_addr == c_A_COMMAND) &&
                          (r_wr_data[3:0] == c_CMD_SOFTRESET);
    assign w_flush      = w_soft_rst ||
                          (r_wr_stb && (r_addr == c_A_FIFOLEVEL) && r_wr_data[7]);

    always_comb begin
        w_rd_data = r_scratch[w_rd_addr];
        case (w_rd_addr)
            c_A_COMMAND:   w_rd_data = {4'h0, r_command};
            c_A_ERROR:     w_rd_data = {3'b000, r_buf_ovfl, 4'h0};
            c_A_FIFODATA:  w_rd_data = w_fifo_empty ? 8'h00 : r_fifo_mem[r_rd_ptr];
            c_A_FIFOLEVEL: w_rd_data = 8'(r_level);
`ifdef MFRC522_SLAVE_IRQ_EN
            c_A_WATER:     w_rd_data = r_water;
`endif
            c_A_VERSION:   w_rd_data = VERSION_VAL;
            default:       ;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM: bit counting, shift registers and miso.
    // miso changes on sck fall, so bit 7 of a loaded byte appears on the
    // fall that follows the previous byte's 8th rise, ahead of the first
    // rise of the byte it belongs to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_bit_cnt <= 3'd0;
            r_rx      <= 7'd0;
            r_tx      <= 8'h00;
            r_miso    <= 1'b0;
            r_rd      <= 1'b0;
            r_addr    <= 6'd0;
            r_wr_stb  <= 1'b0;
            r_wr_data <= 8'h00;
        end else begin
            r_wr_stb <= 1'b0;
            if (w_cs_rise) begin
                // any partial byte is simply dropped here
                r_state   <= c_ST_IDLE;
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
                r_tx      <= 8'h00;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_cs_fall) begin
                            r_state   <= c_ST_ADDR;
                            r_bit_cnt <= 3'd0;
                            r_miso    <= 1'b0;
                            r_tx      <= 8'h00;
                        end
                    end
                    c_ST_ADDR: begin
                        if (w_sck_rise) begin
                            r_rx      <= w_rx_next[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= c_ST_DATA;
                                r_rd    <= w_rx_next[7];
                                r_addr  <= w_rx_next[6:1];
                                r_tx    <= w_load ? w_rd_data : 8'h00;
                            end
                        end
                    end
                    c_ST_DATA: begin
                        if (w_sck_rise) begin
                            r_rx      <= w_rx_next[6:0];
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_rd) begin
                                    r_tx <= w_rd_data;
                                end else begin
                                    r_wr_stb  <= 1'b1;
                                    r_wr_data <= w_rx_next;
                                end
                            end
                        end else if (w_sck_fall) begin
                            r_miso <= r_tx[7];
                            r_tx   <= {r_tx[6:0], 1'b0};
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign miso = r_miso;

    // ------------------------------------------------------------------
    // Register writes and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_command  <= 4'h0;
            r_buf_ovfl <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            for (int i = 0; i < 64; i++) begin
                r_scratch[i] <= 8'h00;
            end
`ifdef MFRC522_SLAVE_IRQ_EN
            r_water    <= 8'h08;
`endif
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + c_LVL_ONE;
                end else if (!w_push && w_pop) begin
                    r_level <= r_level - c_LVL_ONE;
                end
            end

            if (r_wr_stb) begin
                case (r_addr)
                    c_A_COMMAND:   r_command <= w_soft_rst ? 4'h0 : r_wr_data[3:0];
                    c_A_ERROR:     ;
                    c_A_VERSION:   ;
                    c_A_FIFODATA: begin
                        if (w_fifo_full) begin
                            r_buf_ovfl <= 1'b1;
                        end
                    end
                    c_A_FIFOLEVEL: begin
                        if (r_wr_data[7]) begin
                            r_buf_ovfl <= 1'b0;
                        end
                    end
`ifdef MFRC522_SLAVE_IRQ_EN
                    c_A_WATER:     r_water <= r_wr_data;
`endif
                    default:       r_scratch[r_addr] <= r_wr_data;
                endcase
                if (w_soft_rst) begin
                    r_buf_ovfl <= 1'b0;
                    for (int i = 0; i < 64; i++) begin
                        r_scratch[i] <= 8'h00;
                    end
                end
            end
        end
    end

    // FIFO storage needs no reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= r_wr_data;
        end
    end

`ifdef MFRC522_SLAVE_IRQ_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= (8'(r_level) >= r_water) || r_buf_ovfl;
        end
    end

    assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfrc522_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfrc522_spi_slave
// Purpose  : Self-checking bench for mfrc522_spi_slave. Drives SPI mode-0
//            frames, checks directed vectors, hand-written corner sequences
//            and random frames against a register-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfrc522_spi_slave;

    localparam int HALF = 5;   // sck half period in clk cycles

    logic clk = 1'b0;
    logic rst;
    logic cs_n;
    logic sck;
    logic mosi;
    logic miso;
`ifdef MFRC522_SLAVE_IRQ_EN
    logic irq;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mfrc522_spi_slave dut (
        .clk  (clk),
        .rst  (rst),
        .cs_n (cs_n),
        .sck  (sck),
        .mosi (mosi),
        .miso (miso)
`ifdef MFRC522_SLAVE_IRQ_EN
        ,
        .irq  (irq)
`endif
    );

    // ---------------- frame buffers ----------------
    logic [7:0] f_tx  [80];
    logic [7:0] f_rx  [80];
    logic [7:0] f_exp [80];

    // ---------------- reference model ----------------
    logic [7:0] m_scratch [64];
    logic [7:0] m_fifo [$];
    logic       m_ovfl;
    logic [3:0] m_cmd;
    logic [7:0] m_water;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_scratch[i] = 8'h00;
        m_fifo.delete();
        m_ovfl  = 1'b0;
        m_cmd   = 4'h0;
        m_water = 8'h08;
    endfunction

    function automatic logic [7:0] model_read(input logic [5:0] a);
        case (a)
            6'h01: return {4'h0, m_cmd};
            6'h06: return {3'b000, m_ovfl, 4'h0};
            6'h09: begin
                if (m_fifo.size() == 0) return 8'h00;
                return m_fifo.pop_front();
            end
            6'h0A: return 8'(m_fifo.size());
`ifdef MFRC522_SLAVE_IRQ_EN
            6'h0B: return m_water;
`endif
            6'h37: return 8'h92;
            default: return m_scratch[a];
        endcase
    endfunction

    function automatic void model_write(input logic [5:0] a, input logic [7:0] d);
        case (a)
            6'h01: begin
                if (d[3:0] == 4'hF) begin
                    m_fifo.delete();
                    m_ovfl = 1'b0;
                    for (int i = 0; i < 64; i++) m_scratch[i] = 8'h00;
                    m_cmd = 4'h0;
                end else begin
                    m_cmd = d[3:0];
                end
            end
            6'h06, 6'h37: ;
            6'h09: begin
                if (m_fifo.size() >= 64) m_ovfl = 1'b1;
                else m_fifo.push_back(d);
            end
            6'h0A: begin
                if (d[7]) begin
                    m_fifo.delete();
                    m_ovfl = 1'b0;
                end
            end
`ifdef MFRC522_SLAVE_IRQ_EN
            6'h0B: m_water = d;
`endif
            default: m_scratch[a] = d;
        endcase
    endfunction

    // Applies a frame of n complete bytes to the model, fills f_exp.
    // Read frames fetch one value per completed byte; the last one is
    // fetched (and popped, for 0x09) even though the frame ends before
    // it is shifted out.
    function automatic void model_frame(input int n);
        logic [7:0] v;
        f_exp[0] = 8'h00;
        if (f_tx[0][7]) begin
            for (int i = 1; i <= n; i++) begin
                v = model_read(f_tx[i-1][6:1]);
                if (i < n) f_exp[i] = v;
            end
        end else begin
            for (int i = 1; i < n; i++) begin
                model_write(f_tx[0][6:1], f_tx[i]);
                f_exp[i] = 8'h00;
            end
        end
    endfunction

    // ---------------- helpers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = tx[i];
            wait_clk(HALF);
            rx[i] = miso;
            sck = 1'b1;
            wait_clk(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int n);
        cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < n; i++) spi_bits(f_tx[i], 8, f_rx[i]);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(3 * HALF);
    endtask

    // one two-byte read frame, returns byte 2 (and keeps the model in step)
    task automatic read_reg(input logic [7:0] cmd, output logic [7:0] val);
        f_tx[0] = cmd;
        f_tx[1] = 8'h00;
        run_frame(2);
        model_frame(2);
        val = f_rx[1];
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          n;
        logic [31:0] b;
        logic [31:0] e;
        string       name;
    } vec_t;

    vec_t vt [40];
    int   nv = 0;

    task automatic add_vec(input int n, input logic [31:0] b, input logic [31:0] e, input string name);
        vt[nv].n    = n;
        vt[nv].b    = b;
        vt[nv].e    = e;
        vt[nv].name = name;
        nv++;
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[31-8*i -: 8];
    endfunction

    logic [5:0] rand_addr;
    logic [7:0] rd;

    function automatic logic [5:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 6'h01;
            1: return 6'h06;
            2: return 6'h09;
            3: return 6'h0A;
            4: return 6'h37;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        model_reset();

        add_vec(2, 32'hEE00_0000, 32'h0092_0000, "ver_rd");
        add_vec(2, 32'h8200_0000, 32'h0000_0000, "cmd_reset_val");
        add_vec(2, 32'h9400_0000, 32'h0000_0000, "lvl_reset_val");
        add_vec(2, 32'h8C00_0000, 32'h0000_0000, "err_reset_val");
        add_vec(2, 32'hC000_0000, 32'h0000_0000, "scr_reset_val");
        add_vec(2, 32'h6E55_0000, 32'h0000_0000, "ver_wr");
        add_vec(2, 32'hEE00_0000, 32'h0092_0000, "ver_rd_after_wr");
        add_vec(2, 32'h12AB_0000, 32'h0000_0000, "push_ab");
        add_vec(2, 32'h9400_0000, 32'h0001_0000, "lvl_one");
        add_vec(2, 32'h9200_0000, 32'h00AB_0000, "pop_ab");
        add_vec(2, 32'h9400_0000, 32'h0000_0000, "lvl_zero");
        add_vec(2, 32'h9200_0000, 32'h0000_0000, "pop_empty");
        add_vec(4, 32'h1211_2233, 32'h0000_0000, "push3");
        add_vec(4, 32'h9292_9200, 32'h0011_2233, "burst");
        add_vec(2, 32'h0205_0000, 32'h0000_0000, "cmd_wr");
        add_vec(2, 32'h8200_0000, 32'h0005_0000, "cmd_rd");
        add_vec(2, 32'h405A_0000, 32'h0000_0000, "scr_wr");
        add_vec(3, 32'hC0C0_0000, 32'h005A_5A00, "scr_rd_burst");
        add_vec(4, 32'h1201_0203, 32'h0000_0000, "push3b");
        add_vec(2, 32'h020F_0000, 32'h0000_0000, "soft_reset");
        add_vec(2, 32'h9400_0000, 32'h0000_0000, "lvl_after_sr");
        add_vec(2, 32'h8200_0000, 32'h0000_0000, "cmd_after_sr");
        add_vec(2, 32'hC000_0000, 32'h0000_0000, "scr_after_sr");
        add_vec(2, 32'h1277_0000, 32'h0000_0000, "push_77");
        add_vec(2, 32'h1480_0000, 32'h0000_0000, "flush");
        add_vec(2, 32'h9400_0000, 32'h0000_0000, "lvl_after_flush");
        add_vec(2, 32'h0CFF_0000, 32'h0000_0000, "err_wr");
        add_vec(2, 32'h8C00_0000, 32'h0000_0000, "err_ro");

        wait_clk(4);
        check8("miso_in_reset", {7'd0, miso}, 8'h00);
        rst = 1'b0;
        wait_clk(6);
        check8("miso_idle", {7'd0, miso}, 8'h00);

        // ---------- table-driven vectors ----------
        for (int v = 0; v < nv; v++) begin
            for (int i = 0; i < vt[v].n; i++) f_tx[i] = byte_of(vt[v].b, i);
            run_frame(vt[v].n);
            model_frame(vt[v].n);
            for (int i = 0; i < vt[v].n; i++)
                check8($sformatf("%s[%0d]", vt[v].name, i), f_rx[i], byte_of(vt[v].e, i));
        end

        // ---------- overflow: 65 pushes, 64 pops ----------
        f_tx[0] = 8'h12;
        for (int i = 0; i < 65; i++) f_tx[i+1] = 8'(i);
        run_frame(66);
        model_frame(66);
        read_reg(8'h94, rd);
        check8("ovf_level", rd, 8'h40);
        read_reg(8'h8C, rd);
        check8("ovf_error", rd, 8'h10);
`ifdef MFRC522_SLAVE_IRQ_EN
        check8("ovf_irq", {7'd0, irq}, 8'h01);
`endif
        for (int i = 0; i < 64; i++) f_tx[i] = 8'h92;
        f_tx[64] = 8'h00;
        run_frame(65);
        model_frame(65);
        for (int i = 1; i <= 64; i++) check8($sformatf("ovf_pop[%0d]", i - 1), f_rx[i], 8'(i - 1));
        read_reg(8'h94, rd);
        check8("ovf_level_drained", rd, 8'h00);
        read_reg(8'h8C, rd);
        check8("ovf_error_sticky", rd, 8'h10);
        f_tx[0] = 8'h14; f_tx[1] = 8'h80;
        run_frame(2); model_frame(2);
        read_reg(8'h8C, rd);
        check8("ovf_error_cleared", rd, 8'h00);

        // ---------- partial data byte: no write ----------
        f_tx[0] = 8'h40; f_tx[1] = 8'h3C;
        run_frame(2); model_frame(2);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h40, 8, rd);
        spi_bits(8'hFF, 5, rd);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(3 * HALF);
        f_tx[0] = 8'h40; model_frame(1);
        read_reg(8'hC0, rd);
        check8("partial_no_write", rd, 8'h3C);

        // ---------- partial burst byte: no extra pop ----------
        f_tx[0] = 8'h12; f_tx[1] = 8'h77; f_tx[2] = 8'h88;
        run_frame(3); model_frame(3);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h92, 8, rd);
        spi_bits(8'h92, 5, rd);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(3 * HALF);
        f_tx[0] = 8'h92; model_frame(1);
        check8("partial_rd_bits", rd, 8'h70);
        read_reg(8'h94, rd);
        check8("partial_rd_level", rd, 8'h01);
        read_reg(8'h92, rd);
        check8("partial_rd_next", rd, 8'h88);

        // ---------- reset in mid-frame ----------
        f_tx[0] = 8'h40; f_tx[1] = 8'hA5;
        run_frame(2); model_frame(2);
        cs_n = 1'b0;
        wait_clk(HALF);
        spi_bits(8'h40, 8, rd);
        spi_bits(8'h55, 4, rd);
        rst = 1'b1;
        wait_clk(3);
        check8("miso_mid_rst", {7'd0, miso}, 8'h00);
        rst = 1'b0;
        model_reset();
        wait_clk(2);
        // bytes clocked without a fresh cs_n fall must be ignored
        spi_bits(8'h40, 8, rd);
        spi_bits(8'h99, 8, rd);
        check8("rst_frame_miso", rd, 8'h00);
        wait_clk(HALF);
        cs_n = 1'b1;
        wait_clk(3 * HALF);
        read_reg(8'hC0, rd);
        check8("rst_scratch", rd, 8'h00);
        read_reg(8'hEE, rd);
        check8("rst_version", rd, 8'h92);

        // ---------- random frames against the model ----------
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(2, 4);
            rand_addr = pick_addr();
            f_tx[0] = {1'($urandom_range(0, 1)), rand_addr, 1'($urandom_range(0, 1))};
            for (int i = 1; i < n; i++) begin
                if (f_tx[0][7]) f_tx[i] = {1'($urandom_range(0, 1)), pick_addr(), 1'b0};
                else            f_tx[i] = 8'($urandom_range(0, 255));
            end
            run_frame(n);
            model_frame(n);
            for (int i = 0; i < n; i++)
                check8($sformatf("rand%0d[%0d] tx=%02h", t, i, f_tx[i]), f_rx[i], f_exp[i]);
        end
        read_reg(8'h94, rd);
        check8("rand_final_level", rd, f_exp[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mfrc522_spi_slave.md
MFRC522_SPI_SLAVE -- requirements
Module: mfrc522_spi_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 64: FIFODataReg FIFO entries, power of two, 4..64.
REQ-002 Parameter VERSION_VAL, default 8'h92: value returned by VersionReg 0x37.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer flops on cs_n/sck/mosi, range 2..3.
REQ-004 clk  in  1  system clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 cs_n  in  1  SPI chip select, active low, asynchronous to clk.
REQ-007 sck  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0), MSB first.
REQ-008 mosi  in  1  master-to-slave data.
REQ-009 miso  out  1  slave-to-master data; driven 0 while cs_n high (no tristate).

Function
REQ-010 cs_n, sck and mosi SHALL pass through SYNC_STAGES flops, with edge detection on the synchronized copies; sck high and low phases are each at least SYNC_STAGES+2 clk.
REQ-011 The FSM SHALL have three states: IDLE, ADDR and DATA. cs_n fall: IDLE->ADDR. 8th sck rise in ADDR: ->DATA. cs_n rise from any state: ->IDLE.
REQ-012 Address byte: bit7=1 read, bit7=0 write; bits6:1 = register address; bit0 ignored.
REQ-013 mosi SHALL be sampled on sck rise; miso SHALL update on sck fall, and its first bit SHALL be valid before the first sck rise of a byte.
REQ-014 Read: during the byte after the address byte, miso SHALL shift out the register value. Each further MOSI byte in the same frame is a new read address, and its data is returned in the following byte (burst). miso SHALL be 0 during the address byte.
REQ-015 Write: each complete 8-bit MOSI byte after the address byte SHALL be written to the latched address (repeated writes to the same address), with the write occurring 1 clk after the 8th rise.
REQ-016 A frame ended by cs_n rise with a partial byte SHALL discard that byte: no write, no FIFO pop.
REQ-017 Register map: 0x01 CommandReg, rw bits3:0; 0x06 ErrorReg, ro, bit4=BufferOvfl; 0x09 FIFODataReg; 0x0A FIFOLevelReg; 0x37 VersionReg = VERSION_VAL, ro; all other addresses are 8-bit rw scratch registers, reset 0x00.
REQ-018 A write to 0x09 SHALL push to the FIFO. If full, the data is dropped and BufferOvfl is set.
REQ-019 A read of 0x09 SHALL pop the FIFO at the moment the byte is loaded into the shift register. If empty, the read returns 0x00 with no pop.
REQ-020 A read of 0x0A SHALL return {1'b0, level[6:0]}. A write with bit7=1 SHALL flush the FIFO and clear BufferOvfl.
REQ-021 Writing 0x0F to CommandReg SHALL trigger a soft reset:
- flush the FIFO;
- clear BufferOvfl and the scratch registers;
- CommandReg reads 0x00 from 1 clk later.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH. The level counter SHALL be log2(FIFO_DEPTH)+1 bits wide, and level==FIFO_DEPTH means full.
REQ-023 Writes to read-only addresses SHALL be ignored.

Reset
REQ-024 rst SHALL asynchronously force:
- FSM to IDLE, miso=0, bit counter=0;
- FIFO empty, BufferOvfl=0;
- CommandReg and scratch registers = 0x00.
REQ-025 rst asserted mid-frame SHALL abort the frame. The next transfer starts only at a new cs_n fall.

Configuration
REQ-026 When MFRC522_SLAVE_IRQ_EN is defined, the block SHALL add output irq (1 bit, registered, reset 0).
- irq=1 while FIFO level >= WaterLevelReg (0x0B, rw, reset 0x08).
- irq=1 while BufferOvfl=1.
REQ-027 Without MFRC522_SLAVE_IRQ_EN:
- no irq port;
- 0x0B is an ordinary scratch register.

Verification
REQ-028 Write frame 0x12,0xAB (write 0x09 <= 0xAB), then read frame 0x92,0x00 -> miso byte 2 = 0xAB; FIFOLevelReg then reads 0x00.
REQ-029 Read frame 0xEE,0x00 (addr 0x37) -> 0x92; a write frame 0x6E,0x55 -> the next read still returns 0x92.
REQ-030 Write 0x02,0x0F (CommandReg soft reset) after 3 FIFO pushes -> FIFOLevelReg reads 0x00 and CommandReg reads 0x00.
REQ-031 65 pushes of 0x00..0x40 -> level 0x40, ErrorReg bit4=1, and 64 pops return 0x00..0x3F; with IRQ_EN, irq=1.
REQ-032 cs_n rises after 5 bits of the data byte -> no register change; assert rst mid-frame, then a new frame reads VersionReg -> 0x92.
REQ-033 Burst read frame 0x92,0x92,0x92,0x00 after pushing 0x11,0x22,0x33 -> miso bytes 2..4 = 0x11,0x22,0x33.
